// File: rtl/fb_rect_fill_if.sv
// rtl/fb_rect_fill_if.sv - request/status/framebuffer-write bundle for fb_rect_fill
// Purpose: groups the fill request inputs, status outputs and the registered
//          framebuffer write port into one interface.
// Signals:
//   start, oe          fill request and write permission (master -> slave)
//   x0, y0, x1, y1     signed opposite rectangle corners, inclusive
//   cidx               fill colour index
//   busy, done         status (slave -> master)
//   we, addr_write,    framebuffer write side (slave -> master)
//   colr_write
interface fb_rect_fill_if #(
   parameter int CORDW    = 16,
   parameter int FB_DATAW = 4,
   parameter int FB_ADDRW = 15
);
   logic                       start;
   logic                       oe;
   logic signed [CORDW-1:0]    x0, y0, x1, y1;
   logic        [FB_DATAW-1:0] cidx;
   logic                       busy;
   logic                       done;
   logic                       we;
   logic        [FB_ADDRW-1:0] addr_write;
   logic        [FB_DATAW-1:0] colr_write;

   modport master (
      output start, oe, x0, y0, x1, y1, cidx,
      input  busy, done, we, addr_write, colr_write
   );

   modport slave (
      input  start, oe, x0, y0, x1, y1, cidx,
      output busy, done, we, addr_write, colr_write
   );
endinterface

// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - clipped solid rectangle fill into a framebuffer
// Purpose: on start, latches two corners and a colour, sorts and clips the
//          rectangle to the framebuffer and writes every covered pixel in
//          row-major order, one pixel per clock while oe is high.
// Ports:
//   clk_pix   pixel clock, all logic on posedge
//   rst_pix   synchronous active-high reset
//   bus       fb_rect_fill_if.slave: start/oe/x0/y0/x1/y1/cidx in,
//             busy/done/we/addr_write/colr_write out (all outputs registered)
module fb_rect_fill #(
   parameter int CORDW     = 16,
   parameter int FB_WIDTH  = 160,
   parameter int FB_HEIGHT = 120,
   parameter int FB_DATAW  = 4
) (
   input  logic          clk_pix,
   input  logic          rst_pix,
   fb_rect_fill_if.slave bus
);
   localparam int FB_ADDRW = $clog2(FB_WIDTH * FB_HEIGHT);

   localparam logic signed [CORDW-1:0] X_LAST   = CORDW'(FB_WIDTH - 1);
   localparam logic signed [CORDW-1:0] Y_LAST   = CORDW'(FB_HEIGHT - 1);
   localparam logic signed [CORDW-1:0] ONE      = CORDW'(1);
   localparam logic [FB_ADDRW-1:0]     ROW_STEP = FB_ADDRW'(FB_WIDTH);

   typedef enum logic [1:0] {IDLE, INIT, FILL, DONE} state_t;
   state_t state;

   // request captured at acceptance so later input changes cannot disturb the fill
   logic signed [CORDW-1:0]    lx0, ly0, lx1, ly1;
   logic        [FB_DATAW-1:0] lcol;

   // fill cursor and clipped bounds (always non-negative once loaded)
   logic signed [CORDW-1:0]    x, y, xmin, xmax, ymax;
   logic        [FB_ADDRW-1:0] row_base;

   logic signed [CORDW-1:0]    sx_min, sx_max, sy_min, sy_max;
   logic signed [CORDW-1:0]    cx_min, cx_max, cy_min, cy_max;
   logic                       empty;

   // sort and clip the latched corners; only consumed in INIT
   always_comb begin
      sx_min = (lx0 < lx1) ? lx0 : lx1;
      sx_max = (lx0 < lx1) ? lx1 : lx0;
      sy_min = (ly0 < ly1) ? ly0 : ly1;
      sy_max = (ly0 < ly1) ? ly1 : ly0;

      // a negative max or a min past the last pixel leaves nothing on screen
      empty = sx_max[CORDW-1] || (sx_min > X_LAST) ||
              sy_max[CORDW-1] || (sy_min > Y_LAST);

      cx_min = sx_min[CORDW-1] ? '0 : sx_min;
      cy_min = sy_min[CORDW-1] ? '0 : sy_min;
      cx_max = (sx_max > X_LAST) ? X_LAST : sx_max;
      cy_max = (sy_max > Y_LAST) ? Y_LAST : sy_max;
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         state          <= IDLE;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.we         <= 1'b0;
         bus.addr_write <= '0;
         bus.colr_write <= '0;
      end else begin
         bus.we <= 1'b0;
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               if (bus.start) begin
                  lx0      <= bus.x0;
                  ly0      <= bus.y0;
                  lx1      <= bus.x1;
                  ly1      <= bus.y1;
                  lcol     <= bus.cidx;
                  bus.busy <= 1'b1;
                  state    <= INIT;
               end
            end
            INIT: begin
               x        <= cx_min;
               y        <= cy_min;
               xmin     <= cx_min;
               xmax     <= cx_max;
               ymax     <= cy_max;
               row_base <= FB_ADDRW'($unsigned(cy_min)) * ROW_STEP;
               state    <= empty ? DONE : FILL;
            end
            FILL: begin
               // oe low simply skips this edge; cursor holds so nothing is lost
               if (bus.oe) begin
                  bus.we         <= 1'b1;
                  bus.addr_write <= row_base + FB_ADDRW'($unsigned(x));
                  bus.colr_write <= lcol;
                  if (x == xmax) begin
                     if (y == ymax) begin
                        state <= DONE;
                     end else begin
                        x        <= xmin;
                        y        <= y + ONE;
                        row_base <= row_base + ROW_STEP;
                     end
                  end else begin
                     x <= x + ONE;
                  end
               end
            end
            DONE: begin
               bus.done <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_rect_fill.sv
// tb/tb_fb_rect_fill.sv - self-checking bench for fb_rect_fill
module tb_fb_rect_fill;
   localparam int CORDW     = 16;
   localparam int FB_WIDTH  = 160;
   localparam int FB_HEIGHT = 120;
   localparam int FB_DATAW  = 4;
   localparam int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT);

   logic clk_pix = 1'b0;
   logic rst_pix;

   fb_rect_fill_if #(.CORDW(CORDW), .FB_DATAW(FB_DATAW), .FB_ADDRW(FB_ADDRW)) bus ();

   fb_rect_fill #(
      .CORDW(CORDW), .FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT), .FB_DATAW(FB_DATAW)
   ) dut (
      .clk_pix(clk_pix),
      .rst_pix(rst_pix),
      .bus(bus)
   );

   always #5 clk_pix = ~clk_pix;

   int checks = 0;
   int failures = 0;

   // observation log, sampled on the falling edge
   int ncyc = 0;
   int wq_addr[$];
   int wq_colr[$];
   int wq_cyc[$];
   int done_q[$];
   bit oe_at[0:131071];
   bit busy_at[0:131071];

   always @(negedge clk_pix) begin
      oe_at[ncyc]   = bus.oe;
      busy_at[ncyc] = bus.busy;
      if (bus.we === 1'b1) begin
         wq_addr.push_back(int'(bus.addr_write));
         wq_colr.push_back(int'(bus.colr_write));
         wq_cyc.push_back(ncyc);
      end
      if (bus.done === 1'b1) done_q.push_back(ncyc);
      ncyc++;
   end

   // reference: list of pixel addresses the clipped rectangle covers, row-major
   int exp_q[$];

   function automatic void model(input int ax0, input int ay0, input int ax1, input int ay1);
      int xmin, xmax, ymin, ymax;
      exp_q.delete();
      xmin = (ax0 < ax1) ? ax0 : ax1;
      xmax = (ax0 < ax1) ? ax1 : ax0;
      ymin = (ay0 < ay1) ? ay0 : ay1;
      ymax = (ay0 < ay1) ? ay1 : ay0;
      if (xmax < 0 || xmin >= FB_WIDTH || ymax < 0 || ymin >= FB_HEIGHT) return;
      if (xmin < 0) xmin = 0;
      if (ymin < 0) ymin = 0;
      if (xmax > FB_WIDTH - 1) xmax = FB_WIDTH - 1;
      if (ymax > FB_HEIGHT - 1) ymax = FB_HEIGHT - 1;
      for (int yy = ymin; yy <= ymax; yy++)
         for (int xx = xmin; xx <= xmax; xx++)
            exp_q.push_back(yy * FB_WIDTH + xx);
   endfunction

   function automatic int seq_errs();
      int e = 0;
      if (wq_addr.size() != exp_q.size()) return -1;
      foreach (exp_q[i]) if (wq_addr[i] != exp_q[i]) e++;
      return e;
   endfunction

   function automatic int col_errs(input int c);
      int e = 0;
      foreach (wq_colr[i]) if (wq_colr[i] != c) e++;
      return e;
   endfunction

   // a write may only follow an edge at which oe was high
   function automatic int oe_errs();
      int e = 0;
      foreach (wq_cyc[i]) if (wq_cyc[i] == 0 || oe_at[wq_cyc[i] - 1] !== 1'b1) e++;
      return e;
   endfunction

   int acc_cyc;
   bit tmo;

   // mode 0: oe always high, 1: toggling, 2: random. poke re-pulses start mid-fill
   // with scrambled inputs.
   task automatic do_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int c, input int mode, input bit poke);
      int budget;
      model(ax0, ay0, ax1, ay1);
      wq_addr.delete(); wq_colr.delete(); wq_cyc.delete(); done_q.delete();
      @(posedge clk_pix); #1;
      bus.x0 = CORDW'(ax0); bus.y0 = CORDW'(ay0);
      bus.x1 = CORDW'(ax1); bus.y1 = CORDW'(ay1);
      bus.cidx = FB_DATAW'(c);
      bus.oe = 1'b1;
      bus.start = 1'b1;
      @(posedge clk_pix); #1;
      acc_cyc = ncyc;
      bus.start = 1'b0;
      budget = 4 * exp_q.size() + 40;
      tmo = 1'b1;
      for (int k = 0; k < budget; k++) begin
         case (mode)
            0:       bus.oe = 1'b1;
            1:       bus.oe = ((k % 2) == 1);
            default: bus.oe = 1'($urandom_range(0, 1));
         endcase
         if (poke && k == 5) begin
            bus.start = 1'b1;
            bus.x0 = CORDW'(int'($urandom_range(0, 100)));
            bus.y0 = CORDW'(int'($urandom_range(0, 100)));
            bus.x1 = CORDW'(int'($urandom_range(0, 100)));
            bus.y1 = CORDW'(int'($urandom_range(0, 100)));
            bus.cidx = ~FB_DATAW'(c);
         end else if (poke && k == 6) begin
            bus.start = 1'b0;
         end
         if (done_q.size() > 0) begin
            tmo = 1'b0;
            break;
         end
         @(posedge clk_pix); #1;
      end
      bus.start = 1'b0;
      bus.oe = 1'b1;
      repeat (4) @(posedge clk_pix);
      #1;
   endtask

   task automatic test_reset();
      rst_pix = 1'b1;
      bus.start = 1'b1; bus.oe = 1'b1;
      bus.x0 = 0; bus.y0 = 0; bus.x1 = 5; bus.y1 = 5; bus.cidx = 4'hF;
      repeat (3) @(posedge clk_pix);
      @(negedge clk_pix);
      checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL reset_we: got %0b expected 0", bus.we); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
      checks++; if (bus.addr_write !== '0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", bus.addr_write); end
      checks++; if (bus.colr_write !== '0) begin failures++; $display("FAIL reset_colr: got %0d expected 0", bus.colr_write); end
      @(posedge clk_pix); #1;
      bus.start = 1'b0;
      rst_pix = 1'b0;
      repeat (3) @(posedge clk_pix);
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %0b expected 0", bus.busy); end
   endtask

   task automatic test_full_screen();
      int bad;
      do_fill(0, 0, 159, 119, 10, 0, 1'b0);
      checks++; if (tmo) begin failures++; $display("FAIL full_timeout: got no done expected done"); end
      checks++; if (wq_addr.size() !== 19200) begin failures++; $display("FAIL full_count: got %0d expected 19200", wq_addr.size()); end
      bad = 0;
      foreach (wq_addr[i]) if (wq_addr[i] != i) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL full_addr_seq: got %0d bad addresses expected 0", bad); end
      bad = col_errs(10);
      checks++; if (bad !== 0) begin failures++; $display("FAIL full_colr: got %0d bad colours expected 0", bad); end
      bad = 0;
      foreach (wq_cyc[i]) if (wq_cyc[i] != acc_cyc + 2 + i) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL full_consecutive: got %0d off-cycle writes expected 0", bad); end
      checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL full_done_count: got %0d expected 1", done_q.size()); end
      if (done_q.size() > 0 && wq_cyc.size() > 0) begin
         checks++; if (done_q[0] !== wq_cyc[$] + 1) begin failures++; $display("FAIL full_done_cycle: got %0d expected %0d", done_q[0], wq_cyc[$] + 1); end
      end
   endtask

   task automatic test_swapped();
      int bad;
      int lit[12] = '{487, 488, 489, 490, 647, 648, 649, 650, 807, 808, 809, 810};
      do_fill(10, 5, 7, 3, 6, 0, 1'b0);
      checks++; if (wq_addr.size() !== 12) begin failures++; $display("FAIL swap_count: got %0d expected 12", wq_addr.size()); end
      bad = 0;
      foreach (lit[i]) if (i >= wq_addr.size() || wq_addr[i] != lit[i]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL swap_addr: got %0d bad addresses expected 0", bad); end
      checks++; if (wq_cyc.size() > 0 && wq_cyc[0] !== acc_cyc + 2) begin failures++; $display("FAIL swap_first_we: got cycle %0d expected %0d", wq_cyc[0], acc_cyc + 2); end
      checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL swap_done_count: got %0d expected 1", done_q.size()); end
      checks++; if (busy_at[acc_cyc - 1] !== 1'b0 || busy_at[acc_cyc] !== 1'b1) begin
         failures++; $display("FAIL swap_busy_rise: got %0b%0b expected 01", busy_at[acc_cyc - 1], busy_at[acc_cyc]);
      end
      if (done_q.size() > 0) begin
         checks++; if (busy_at[done_q[0]] !== 1'b1 || busy_at[done_q[0] + 1] !== 1'b0) begin
            failures++; $display("FAIL swap_busy_fall: got %0b%0b expected 10", busy_at[done_q[0]], busy_at[done_q[0] + 1]);
         end
      end
   endtask

   task automatic test_clip();
      int bad;
      int lit[6] = '{0, 1, 2, 160, 161, 162};
      do_fill(-5, -2, 2, 1, 9, 0, 1'b0);
      bad = 0;
      if (wq_addr.size() != 6) bad = -1;
      else foreach (lit[i]) if (wq_addr[i] != lit[i]) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL clip_addr: got %0d writes/%0d errors expected 6/0", wq_addr.size(), bad); end
      checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL clip_done_count: got %0d expected 1", done_q.size()); end
      do_fill(200, 0, 300, 10, 3, 0, 1'b0);
      checks++; if (wq_addr.size() !== 0) begin failures++; $display("FAIL offscreen_count: got %0d expected 0", wq_addr.size()); end
      checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL offscreen_done_count: got %0d expected 1", done_q.size()); end
      if (done_q.size() > 0) begin
         checks++; if (done_q[0] !== acc_cyc + 2) begin failures++; $display("FAIL offscreen_done_cycle: got %0d expected %0d", done_q[0], acc_cyc + 2); end
      end
   endtask

   task automatic test_oe_toggle();
      int bad;
      do_fill(0, 0, 3, 0, 5, 1, 1'b0);
      checks++; if (wq_addr.size() !== 4) begin failures++; $display("FAIL toggle_count: got %0d expected 4", wq_addr.size()); end
      bad = seq_errs();
      checks++; if (bad !== 0) begin failures++; $display("FAIL toggle_addr: got %0d errors expected 0", bad); end
      bad = oe_errs();
      checks++; if (bad !== 0) begin failures++; $display("FAIL toggle_stall: got %0d writes after oe low expected 0", bad); end
      checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL toggle_done_count: got %0d expected 1", done_q.size()); end
   endtask

   task automatic test_random();
      int ax0, ay0, ax1, ay1, c, bad;
      for (int n = 0; n < 8; n++) begin
         ax0 = int'($urandom_range(0, 179)) - 10;
         ay0 = int'($urandom_range(0, 139)) - 10;
         ax1 = ax0 + int'($urandom_range(0, 30)) - 15;
         ay1 = ay0 + int'($urandom_range(0, 30)) - 15;
         c   = int'($urandom_range(0, 15));
         do_fill(ax0, ay0, ax1, ay1, c, 2, 1'b0);
         bad = seq_errs();
         checks++; if (bad !== 0) begin failures++; $display("FAIL rand_addr[%0d]: got %0d writes/%0d errors expected %0d/0", n, wq_addr.size(), bad, exp_q.size()); end
         bad = col_errs(c);
         checks++; if (bad !== 0) begin failures++; $display("FAIL rand_colr[%0d]: got %0d bad colours expected 0", n, bad); end
         bad = oe_errs();
         checks++; if (bad !== 0) begin failures++; $display("FAIL rand_stall[%0d]: got %0d writes after oe low expected 0", n, bad); end
         checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL rand_done[%0d]: got %0d expected 1", n, done_q.size()); end
      end
   endtask

   task automatic test_start_while_busy();
      int bad;
      do_fill(0, 0, 40, 3, 12, 0, 1'b1);
      bad = seq_errs();
      checks++; if (bad !== 0) begin failures++; $display("FAIL busy_start_addr: got %0d writes/%0d errors expected %0d/0", wq_addr.size(), bad, exp_q.size()); end
      bad = col_errs(12);
      checks++; if (bad !== 0) begin failures++; $display("FAIL busy_start_colr: got %0d bad colours expected 0", bad); end
      checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL busy_start_done: got %0d expected 1", done_q.size()); end
   endtask

   task automatic test_reset_mid();
      int n_rst, bad;
      bit seen;
      wq_addr.delete(); wq_colr.delete(); wq_cyc.delete(); done_q.delete();
      @(posedge clk_pix); #1;
      bus.x0 = 0; bus.y0 = 0; bus.x1 = 159; bus.y1 = 0; bus.cidx = 4'h7;
      bus.oe = 1'b1; bus.start = 1'b1;
      @(posedge clk_pix); #1;
      bus.start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (wq_addr.size() >= 20) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk_pix); #1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL rmid_reach20: got %0d writes expected 20", wq_addr.size()); end
      rst_pix = 1'b1;
      @(posedge clk_pix);
      @(negedge clk_pix);
      checks++; if (bus.we !== 1'b0) begin failures++; $display("FAIL rmid_we: got %0b expected 0", bus.we); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %0b expected 0", bus.busy); end
      n_rst = wq_addr.size();
      @(posedge clk_pix); #1;
      rst_pix = 1'b0;
      repeat (30) @(posedge clk_pix);
      #1;
      checks++; if (wq_addr.size() !== n_rst) begin failures++; $display("FAIL rmid_more_writes: got %0d expected %0d", wq_addr.size(), n_rst); end
      checks++; if (done_q.size() !== 0) begin failures++; $display("FAIL rmid_done: got %0d expected 0", done_q.size()); end
      bad = 0;
      foreach (wq_addr[i]) if (wq_addr[i] != i) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL rmid_prefix: got %0d bad addresses expected 0", bad); end
      do_fill(5, 5, 8, 6, 3, 0, 1'b0);
      bad = seq_errs();
      checks++; if (bad !== 0) begin failures++; $display("FAIL rmid_restart: got %0d writes/%0d errors expected 8/0", wq_addr.size(), bad); end
      checks++; if (done_q.size() !== 1) begin failures++; $display("FAIL rmid_restart_done: got %0d expected 1", done_q.size()); end
   endtask

   initial begin
      test_reset();
      test_full_screen();
      test_swapped();
      test_clip();
      test_oe_toggle();
      test_random();
      test_start_while_busy();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fb_rect_fill.md
FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 SHALL have parameter CORDW, default 16, signed coordinate width (bits).
REQ-002 SHALL have parameter FB_WIDTH, default 160, framebuffer width (pixels).
REQ-003 SHALL have parameter FB_HEIGHT, default 120, framebuffer height (pixels).
REQ-004 SHALL have parameter FB_DATAW, default 4, colour index width (bits); FB_ADDRW = $clog2(FB_WIDTH*FB_HEIGHT), derived.
REQ-005 SHALL have port clk_pix  input  1  pixel clock; one clock, all logic on posedge.
REQ-006 SHALL have port rst_pix  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  request fill; sampled in IDLE only.
REQ-008 SHALL have port oe  input  1  write permission (e.g. blanking); fill stalls while low.
REQ-009 SHALL have ports x0, y0, x1, y1  input  CORDW signed each  opposite rectangle corners, inclusive.
REQ-010 SHALL have port cidx  input  FB_DATAW  fill colour index.
REQ-011 SHALL have port busy  output  1  high from cycle after start accepted until done cycle inclusive.
REQ-012 SHALL have port done  output  1  single-cycle completion pulse.
REQ-013 SHALL have ports we  output  1, addr_write  output  FB_ADDRW, colr_write  output  FB_DATAW: framebuffer write port, registered, driving bram_sdp write side directly.

Function
REQ-014 SHALL implement FSM states IDLE, INIT, FILL, DONE.
REQ-015 IDLE: start=1 at an edge SHALL latch x0..y1 and cidx and move to INIT; start in any other state SHALL be ignored.
REQ-016 INIT (one cycle) SHALL sort corners (xmin=min(x0,x1), etc.), clip to 0..FB_WIDTH-1 / 0..FB_HEIGHT-1, and compute row base = ymin*FB_WIDTH.
REQ-017 If clipped rectangle is empty (xmax<0, xmin>=FB_WIDTH, ymax<0 or ymin>=FB_HEIGHT) INIT SHALL go to DONE with zero writes; else to FILL at (xmin, ymin).
REQ-018 FILL, each edge with oe=1: SHALL register we=1, addr_write=row_base+x, colr_write=latched cidx, then advance x; at x=xmax, x<=xmin, y<=y+1, row_base<=row_base+FB_WIDTH.
REQ-019 FILL, edge with oe=0: SHALL register we=0 and hold x, y, row_base; no pixel skipped or duplicated.
REQ-020 Pixel order SHALL be row-major, ascending x then ascending y; first we high after third edge from start acceptance when oe high.
REQ-021 After registering the write of (xmax, ymax) FSM SHALL enter DONE; done SHALL be high for exactly the following cycle, then IDLE.
REQ-022 we SHALL be 0 in every state except as set in FILL; addr_write/colr_write undefined-but-stable when we=0 (hold last value).
REQ-023 Total writes SHALL equal (xmax-xmin+1)*(ymax-ymin+1) of clipped rectangle; addr_write SHALL never exceed FB_WIDTH*FB_HEIGHT-1.
REQ-024 Coordinate compares SHALL be signed CORDW; address arithmetic unsigned FB_ADDRW without overflow.
REQ-025 Inputs x0..y1, cidx changing after acceptance SHALL not affect the running fill.

Reset
REQ-026 rst_pix=1 SHALL force state IDLE, busy=0, done=0, we=0, addr_write=0, colr_write=0 at next edge, in any state.
REQ-027 Reset mid-FILL SHALL produce no further writes and no done pulse; a start after reset release SHALL be accepted normally.

Verification
REQ-028 (0,0)-(159,119), cidx=4'hA, oe=1 -> 19200 consecutive we cycles, addr 0..19199 ascending, colr A, one done.
REQ-029 Swapped (10,5)-(7,3), oe=1 -> 12 writes, addr 487-490, 647-650, 807-810 in order, one done.
REQ-030 Clip (-5,-2)-(2,1) -> writes addr 0,1,2,160,161,162 only; off-screen (200,0)-(300,10) -> zero writes, done 2 cycles after acceptance.
REQ-031 (0,0)-(3,0) with oe toggling 1,0,1,0,... -> exactly 4 writes addr 0,1,2,3, we low in cycles following oe=0 edges.
REQ-032 start pulsed again while busy -> ignored, single done; rst_pix during fill of (0,0)-(159,0) after 20 writes -> we=0, busy=0 next cycle, no done.
